gen_updown_counter: RTL and testbench

//  Parameterised modulo up/down counter built from a generate-replicated per-bit cell.

---
 rtl/gen_counter_pkg.sv | 19 +
 rtl/updown_bit_cell.sv | 35 +++
 rtl/gen_updown_counter.sv | 124 ++++++++++++
 tb/tb_gen_updown_counter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_counter_pkg.sv
// Shared constants and helpers for the generate-built up/down counter.
package gen_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_bit_cell.sv
// One bit of the counter: toggles when stepping with an active carry/borrow chain,
// or takes a parallel-load value that the top level uses for clear, load and terminal handling.
module updown_bit_cell (
    input  logic clk,
    input  logic reset,
    input  logic step_i,
    input  logic chain_i,
    input  logic load_i,
    input  logic load_val_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (step_i && chain_i) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/gen_updown_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with prescaler, wrap/saturate terminal handling,
// a registered terminal-count pulse and a sticky overflow flag.
module gen_updown_counter
    import gen_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 1,
    parameter int              SATURATE = 0,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             zero
);

    localparam int               PS_W    = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    logic [PS_W-1:0]  ps_q, ps_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] count_w;
    logic [WIDTH-1:0] chain;
    logic [WIDTH-1:0] cell_val;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] term_val;
    logic             dir_up;
    logic             step;
    logic             at_term;
    logic             term;
    logic             cell_load;

    assign dir_up = (up_dn == DIR_UP);

    // With PRESCALE==1 the prescaler stays at 0 == PS_LAST, so every enabled cycle steps.
    assign step    = en && !clr && !load && (ps_q == PS_LAST);
    assign at_term = dir_up ? (count_w == MAX_W) : (count_w == '0);
    assign term    = step && at_term;

    assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
    assign term_val     = (SATURATE == MODE_SAT) ? count_w : (dir_up ? '0 : MAX_W);

    // Clear, load and the terminal wrap/hold all go through the cells' parallel-load path,
    // so plain binary toggling only ever runs strictly inside 0..MAX_VAL.
    assign cell_load = clr || load || term;
    assign cell_val  = clr ? '0 : (load ? load_clamped : term_val);

    always_comb begin
        logic run;
        run = 1'b1;
        chain = '0;
        for (int i = 0; i < WIDTH; i++) begin
            chain[i] = run;
            run = run & (dir_up ? count_w[i] : ~count_w[i]);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        updown_bit_cell u_cell (
            .clk        (clk),
            .reset      (reset),
            .step_i     (step),
            .chain_i    (chain[g]),
            .load_i     (cell_load),
            .load_val_i (cell_val[g]),
            .q_o        (count_w[g])
        );
    end

    always_comb begin
        ps_d  = ps_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            ps_d  = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            ps_d = '0;
            if (ovf_clr) begin
                ovf_d = 1'b0;
            end
        end else begin
            if (ovf_clr) begin
                ovf_d = 1'b0;
            end
            if (en) begin
                ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
            end
            // A terminal event outranks a coincident ovf_clr.
            if (term) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q  <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ps_q  <= ps_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign count = count_w;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign zero  = (count_w == '0);

endmodule

// File: tb/tb_gen_updown_counter.sv
// Three counter configurations share one stimulus stream and are checked every cycle
// against an arithmetic reference model, plus directed scenarios with literal expectations.
module tb_gen_updown_counter;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up_dn;
    logic       ovf_clr;

    logic [3:0] cnt_o  [3];
    logic       tc_o   [3];
    logic       ovf_o  [3];
    logic       zero_o [3];

    // Instance 0: MAX 9 wrap; 1: MAX 15 saturate; 2: MAX 9 wrap, prescale 3.
    int cfg_max [3] = '{9, 15, 9};
    int cfg_sat [3] = '{0, 1, 0};
    int cfg_ps  [3] = '{1, 1, 3};

    int m_cnt [3];
    int m_ps  [3];
    int m_tc  [3];
    int m_ovf [3];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    gen_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .ovf_clr(ovf_clr),
        .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0])
    );

    gen_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1), .PRESCALE(1)) dut_b (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .ovf_clr(ovf_clr),
        .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1])
    );

    gen_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)) dut_c (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .ovf_clr(ovf_clr),
        .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt = chk_cnt + 1;
        if (act == exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge of instance i, straight from the counting rules.
    task automatic model_edge(input int i);
        int  mx;
        bit  hit;
        mx  = cfg_max[i];
        hit = 1'b0;
        if (clr) begin
            m_cnt[i] = 0;
            m_ps[i]  = 0;
            m_ovf[i] = 0;
            m_tc[i]  = 0;
        end else if (load) begin
            m_cnt[i] = (int'(load_val) > mx) ? mx : int'(load_val);
            m_ps[i]  = 0;
            m_tc[i]  = 0;
            if (ovf_clr) m_ovf[i] = 0;
        end else begin
            m_tc[i] = 0;
            if (ovf_clr) m_ovf[i] = 0;
            if (en) begin
                m_ps[i] = m_ps[i] + 1;
                if (m_ps[i] == cfg_ps[i]) begin
                    m_ps[i] = 0;
                    if (up_dn) begin
                        hit = (m_cnt[i] == mx);
                        if (cfg_sat[i] != 0) m_cnt[i] = hit ? mx : m_cnt[i] + 1;
                        else                 m_cnt[i] = (m_cnt[i] + 1) % (mx + 1);
                    end else begin
                        hit = (m_cnt[i] == 0);
                        if (hit) m_cnt[i] = (cfg_sat[i] != 0) ? 0 : mx;
                        else     m_cnt[i] = m_cnt[i] - 1;
                    end
                    if (hit) begin
                        m_tc[i]  = 1;
                        m_ovf[i] = 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_cnt[i] = 0;
                m_ps[i]  = 0;
                m_tc[i]  = 0;
                m_ovf[i] = 0;
            end else begin
                model_edge(i);
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_cnt%0d", i),  int'(cnt_o[i]),  m_cnt[i]);
            check($sformatf("model_tc%0d", i),   int'(tc_o[i]),   m_tc[i]);
            check($sformatf("model_ovf%0d", i),  int'(ovf_o[i]),  m_ovf[i]);
            check($sformatf("model_zero%0d", i), int'(zero_o[i]), (m_cnt[i] == 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                         input logic e, input logic u, input logic oc);
        clr      = c;
        load     = l;
        load_val = lv;
        en       = e;
        up_dn    = u;
        ovf_clr  = oc;
    endtask

    initial begin
        int exp1 [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
        int exp2 [4]  = '{1, 0, 9, 8};
        int exp4 [7]  = '{0, 0, 0, 1, 1, 1, 2};
        int en4  [7]  = '{1, 1, 0, 1, 1, 1, 1};

        reset = 1'b1;
        drive(0, 0, 4'd0, 0, 1, 0);
        tick();
        tick();
        reset = 1'b0;
        check("reset_cnt", int'(cnt_o[0]), 0);
        check("reset_zero", int'(zero_o[0]), 1);
        check("reset_ovf", int'(ovf_o[0]), 0);

        // Wrap up-count through the terminal value.
        drive(0, 0, 4'd0, 1, 1, 0);
        for (int k = 0; k < 11; k++) begin
            tick();
            check("t1_cnt", int'(cnt_o[0]), exp1[k]);
            check("t1_tc", int'(tc_o[0]), (k == 9) ? 1 : 0);
            check("t1_ovf", int'(ovf_o[0]), (k >= 9) ? 1 : 0);
        end

        // Down-count through zero from a loaded value.
        drive(0, 1, 4'd2, 0, 0, 0);
        tick();
        check("t2_load", int'(cnt_o[0]), 2);
        drive(0, 0, 4'd0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_cnt", int'(cnt_o[0]), exp2[k]);
            check("t2_tc", int'(tc_o[0]), (k == 2) ? 1 : 0);
            check("t2_zero", int'(zero_o[0]), (k == 1) ? 1 : 0);
        end

        // Saturating instance held at its top value.
        drive(0, 1, 4'd14, 0, 1, 1);
        tick();
        check("t3_load", int'(cnt_o[1]), 14);
        check("t3_ovf0", int'(ovf_o[1]), 0);
        drive(0, 0, 4'd0, 1, 1, 0);
        tick();
        check("t3_cnt_a", int'(cnt_o[1]), 15);
        check("t3_tc_a", int'(tc_o[1]), 0);
        drive(0, 0, 4'd0, 1, 1, 1);
        tick();
        check("t3_cnt_b", int'(cnt_o[1]), 15);
        check("t3_tc_b", int'(tc_o[1]), 1);
        check("t3_ovf_b", int'(ovf_o[1]), 1);
        drive(0, 0, 4'd0, 1, 1, 0);
        tick();
        check("t3_tc_c", int'(tc_o[1]), 1);
        check("t3_ovf_c", int'(ovf_o[1]), 1);
        drive(0, 0, 4'd0, 0, 1, 1);
        tick();
        check("t3_tc_d", int'(tc_o[1]), 0);
        check("t3_ovf_d", int'(ovf_o[1]), 0);

        // Prescaler steps only every third enabled cycle.
        drive(1, 0, 4'd0, 0, 1, 0);
        tick();
        check("t4_clr", int'(cnt_o[2]), 0);
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, 4'd0, en4[k][0], 1, 0);
            tick();
            check("t4_cnt", int'(cnt_o[2]), exp4[k]);
        end

        // Load clamp, then clear outranking load and enable.
        drive(0, 1, 4'd12, 0, 1, 0);
        tick();
        check("t5_clamp", int'(cnt_o[0]), 9);
        drive(0, 0, 4'd0, 1, 1, 0);
        tick();
        check("t5_wrap_ovf", int'(ovf_o[0]), 1);
        drive(1, 1, 4'd7, 1, 1, 0);
        tick();
        check("t5_clr_cnt", int'(cnt_o[0]), 0);
        check("t5_clr_ovf", int'(ovf_o[0]), 0);

        // Asynchronous reset between edges while tc and ovf are high.
        drive(0, 1, 4'd8, 0, 1, 0);
        tick();
        drive(0, 0, 4'd0, 1, 1, 0);
        tick();
        tick();
        check("t6_pre_tc", int'(tc_o[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_cnt", int'(cnt_o[0]), 0);
        check("t6_rst_tc", int'(tc_o[0]), 0);
        check("t6_rst_ovf", int'(ovf_o[0]), 0);
        check("t6_rst_zero", int'(zero_o[0]), 1);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t6_resume_a", int'(cnt_o[0]), k);
            check("t6_resume_c", int'(cnt_o[2]), (k == 3) ? 1 : 0);
        end

        // Randomised traffic checked by the model.
        repeat (400) begin
            drive(($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
            tick();
        end

        drive(0, 0, 4'd0, 0, 1, 0);
        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
